// File: rtl/bitmap_pkg.sv
// Shared definitions for the bitmap scan-out block.
// ADDR_W_DEF / BYTE_W_DEF : default RAM address width and bits per output byte
// NUM_BYTES               : bytes produced by one full scan at the defaults
// state_t                 : scan controller states
package bitmap_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int BYTE_W_DEF = 8;
  localparam int NUM_BYTES  = (2**ADDR_W_DEF) / BYTE_W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/bitmap_scanout_if.sv
// Packed-byte output stream with valid/ready handshake.
// byte_data  : packed bitmap byte (source -> sink)
// byte_valid : byte_data holds a byte (source -> sink)
// byte_ready : sink accepts the byte when high with byte_valid (sink -> source)
// master = producer (bitmap_scanout), slave = consumer.
interface bitmap_scanout_if #(
  parameter int BYTE_W = bitmap_pkg::BYTE_W_DEF
) ();
  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_ready;

  modport master (output byte_data, byte_valid, input byte_ready);
  modport slave  (input byte_data, byte_valid, output byte_ready);
endinterface

// File: rtl/bit_packer.sv
// Serial-to-parallel packer: collects BYTE_W bits MSB-first.
// clk, rst_n : clock, async active-low reset
// clr        : drop any partial byte (start of a scan)
// cap        : capture bit_in this cycle
// bit_in     : incoming bitmap bit
// last       : the next captured bit completes a byte
// byte_out   : the byte that would result if bit_in were captured now
module bit_packer
  import bitmap_pkg::*;
#(
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              cap,
  input  logic              bit_in,
  output logic              last,
  output logic [BYTE_W-1:0] byte_out
);
  localparam int                CNT_W    = $clog2(BYTE_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BYTE_W - 1);

  logic [BYTE_W-2:0] sh;
  logic [CNT_W-1:0]  cnt;

  // Earlier bits sit above the live bit, so the first bit lands in the MSB.
  assign byte_out = {sh, bit_in};
  assign last     = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sh  <= '0;
      cnt <= '0;
    end else if (cap) begin
      sh  <= byte_out[BYTE_W-2:0];
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/bitmap_scanout.sv
// Scans a 1-bit bitmap RAM from address 0 to 2**ADDR_W-1 and emits it as
// MSB-first packed bytes over a valid/ready stream.
// clk, rst_n : clock, async active-low reset
// start      : scan request, honoured only when idle
// ram_addr   : read address to a registered-address RAM
// ram_q      : RAM data, one clock after ram_addr
// busy       : scan in progress
// done       : one-cycle pulse after the final byte is accepted
// bus        : packed byte stream (byte_data / byte_valid / byte_ready)
module bitmap_scanout
  import bitmap_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_q,
  output logic              busy,
  output logic              done,
  bitmap_scanout_if.master  bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_t            state;
  logic              iss_vld;  // ram_addr is a live read whose data should be used
  logic              rd_vld;   // ram_q this cycle is the data for rd_addr
  logic [ADDR_W-1:0] rd_addr;
  logic              last_bit, stall, cap, hs, scan_go;
  logic [BYTE_W-1:0] byte_nxt;

  assign hs      = bus.byte_valid && bus.byte_ready;
  // A completing bit can only be taken if the output register is empty or
  // is being handed off this very cycle.
  assign stall   = last_bit && bus.byte_valid && !bus.byte_ready;
  assign cap     = (state == FETCH) && rd_vld && !stall;
  assign scan_go = (state == IDLE) && start;

  bit_packer #(.BYTE_W(BYTE_W)) u_pack (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (scan_go),
    .cap      (cap),
    .bit_in   (ram_q),
    .last     (last_bit),
    .byte_out (byte_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ram_addr       <= '0;
      rd_addr        <= '0;
      iss_vld        <= 1'b0;
      rd_vld         <= 1'b0;
      bus.byte_data  <= '0;
      bus.byte_valid <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;

      if (cap && last_bit) begin
        bus.byte_data  <= byte_nxt;
        bus.byte_valid <= 1'b1;
      end else if (hs) begin
        bus.byte_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            ram_addr <= '0;
            iss_vld  <= 1'b1;
            rd_vld   <= 1'b0;
          end
        end

        FETCH: begin
          if (cap && rd_addr == LAST_ADDR) begin
            state   <= DRAIN;
            iss_vld <= 1'b0;
            rd_vld  <= 1'b0;
          end else if (rd_vld && stall) begin
            // Bit not taken: re-read it. Anything already issued past it is
            // discarded; if the RAM is already on rd_addr the next word is good.
            ram_addr <= rd_addr;
            iss_vld  <= 1'b1;
            rd_vld   <= (ram_addr == rd_addr);
          end else begin
            rd_addr <= ram_addr;
            rd_vld  <= iss_vld;
            if (iss_vld) begin
              if (ram_addr == LAST_ADDR) iss_vld  <= 1'b0;
              else                       ram_addr <= ram_addr + ONE;
            end
          end
        end

        DRAIN: begin
          if (hs) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bitmap_scanout.sv
// Self-checking bench for bitmap_scanout: table of scan scenarios checked
// against an arithmetic packing model, plus hand-written restart and reset
// sequences.
module tb_bitmap_scanout;
  import bitmap_pkg::*;

  localparam int DEPTH = 2**ADDR_W_DEF;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  ram_q = 1'b0;
  logic [ADDR_W_DEF-1:0] ram_addr;
  logic                  busy, done;

  bitmap_scanout_if #(.BYTE_W(BYTE_W_DEF)) bus ();

  bitmap_scanout #(.ADDR_W(ADDR_W_DEF), .BYTE_W(BYTE_W_DEF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ram_addr (ram_addr),
    .ram_q    (ram_q),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Registered-address bitmap RAM
  logic mem [DEPTH];
  always @(posedge clk) ram_q <= mem[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor: inputs only change just after posedge, so valid&&ready at
  // the falling edge is exactly the handshake of the following rising edge.
  logic [BYTE_W_DEF-1:0] rx_q[$];
  int                    stab_err = 0;
  logic                  pv = 1'b0, pr = 1'b0;
  logic [BYTE_W_DEF-1:0] pd = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr && (!bus.byte_valid || bus.byte_data !== pd)) stab_err++;
      if (bus.byte_valid && bus.byte_ready) rx_q.push_back(bus.byte_data);
      pv = bus.byte_valid;
      pr = bus.byte_ready;
      pd = bus.byte_data;
    end
  end

  int checks = 0, errors = 0;
  int done_seen = 0, ov_cnt = 0;
  int e0, fv, done_rel, base_rx, base_done, base_stab, base_ov;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (done) done_seen++;
    if (busy && done) ov_cnt++;
  endtask

  // Reference packing: byte k is the BYTE_W bits from address BYTE_W*k upward,
  // read as a binary number with the lowest address as the most significant bit.
  function automatic logic [BYTE_W_DEF-1:0] ref_byte(input int k);
    int v = 0;
    for (int i = 0; i < BYTE_W_DEF; i++) v = (v << 1) | int'(mem[BYTE_W_DEF*k + i]);
    return BYTE_W_DEF'(v);
  endfunction

  function automatic int get_rx(input int k);
    if (base_rx + k < rx_q.size()) return int'(rx_q[base_rx + k]);
    return -1;
  endfunction

  // 0: bit = address[0]   1: all ones, last bit cleared   2: all zeros   3: random
  task automatic fill(input int pat);
    for (int a = 0; a < DEPTH; a++) begin
      case (pat)
        0:       mem[a] = a[0];
        1:       mem[a] = (a != DEPTH - 1);
        2:       mem[a] = 1'b0;
        default: mem[a] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low 40 cycles while byte 3 pending
  task automatic run_scan(input int mode, input int restart_at, input int abort_at);
    int n = 0, hold = 0;
    bit hchk = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    e0 = cyc; fv = -1; done_rel = -1;
    base_rx = rx_q.size(); base_done = done_seen; base_stab = stab_err; base_ov = ov_cnt;
    chk("start_addr0", ram_addr, 0);
    chk("busy_after_start", busy, 1);
    while (done_rel < 0 && n < 6000) begin
      if (abort_at >= 0 && rx_q.size() - base_rx >= abort_at) return;
      if (mode == 2 && hold == 40 && !hchk) begin
        chk("stall_valid_held", bus.byte_valid, 1);
        chk("stall_data_held", bus.byte_data, ref_byte(3));
        hchk = 1'b1;
      end
      case (mode)
        1: bus.byte_ready = 1'($urandom_range(0, 1));
        2: begin
          if (rx_q.size() - base_rx == 3 && hold < 40) begin
            bus.byte_ready = 1'b0;
            hold++;
          end else begin
            bus.byte_ready = 1'b1;
          end
        end
        default: bus.byte_ready = 1'b1;
      endcase
      start = (restart_at >= 0 && n == restart_at);
      tick();
      n++;
      if (bus.byte_valid && fv < 0) fv = cyc - e0;
      if (done) done_rel = cyc - e0;
    end
    start = 1'b0;
    bus.byte_ready = 1'b1;
    chk("done_seen", done_rel >= 0, 1);
  endtask

  task automatic verify_scan(input string nm, input int tail);
    int bad = 0;
    int cnt;
    repeat (tail) tick();
    cnt = rx_q.size() - base_rx;
    chk({nm, "_count"}, cnt, NUM_BYTES);
    for (int k = 0; k < NUM_BYTES; k++)
      if (get_rx(k) != int'(ref_byte(k))) bad++;
    chk({nm, "_stream_bad_bytes"}, bad, 0);
    chk({nm, "_done_pulses"}, done_seen - base_done, 1);
    chk({nm, "_hold_violations"}, stab_err - base_stab, 0);
    chk({nm, "_busy_done_overlap"}, ov_cnt - base_ov, 0);
  endtask

  typedef struct {
    int pat;
    int mode;
    int first_b;   // -1: model only
    int last_b;
    int vld_rel;   // edge of first byte_valid after the start edge, -1: any
    int done_rel;  // edge after which done is seen, -1: any
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   n, vcnt;

    vecs[0] = '{0, 0, 'h55, 'h55, 9, 1026};
    vecs[1] = '{1, 0, 'hFF, 'hFE, 9, 1026};
    vecs[2] = '{2, 0, 'h00, 'h00, 9, 1026};
    vecs[3] = '{3, 1, -1, -1, -1, -1};
    vecs[4] = '{3, 1, -1, -1, -1, -1};
    vecs[5] = '{3, 2, -1, -1, 9, -1};

    bus.byte_ready = 1'b1;
    fill(2);
    repeat (3) tick();
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_byte_data", bus.byte_data, 0);
    chk("rst_byte_valid", bus.byte_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].pat);
      run_scan(vecs[v].mode, -1, -1);
      verify_scan($sformatf("vec%0d", v), 4);
      chk($sformatf("vec%0d_idle_valid", v), bus.byte_valid, 0);
      if (vecs[v].first_b >= 0) begin
        chk($sformatf("vec%0d_first_byte", v), get_rx(0), vecs[v].first_b);
        chk($sformatf("vec%0d_last_byte", v), get_rx(NUM_BYTES - 1), vecs[v].last_b);
      end
      if (vecs[v].vld_rel >= 0)
        chk($sformatf("vec%0d_first_valid_edge", v), fv, vecs[v].vld_rel);
      if (vecs[v].done_rel >= 0)
        chk($sformatf("vec%0d_done_edge", v), done_rel, vecs[v].done_rel);
    end

    // Start re-pulsed mid-scan is ignored; start right at done is taken.
    fill(0);
    run_scan(0, 100, -1);
    verify_scan("restart", 0);
    chk("restart_done_edge", done_rel, 1026);
    fill(3);
    run_scan(0, -1, -1);
    verify_scan("b2b", 4);
    chk("b2b_first_valid_edge", fv, 9);

    // Reset in the middle of a scan
    fill(3);
    run_scan(0, -1, 60);
    n = 0;
    while (!bus.byte_valid && n < 20) begin
      tick();
      n++;
    end
    chk("midrst_pre_busy", busy, 1);
    chk("midrst_pre_valid", bus.byte_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ram_addr", ram_addr, 0);
    chk("midrst_byte_data", bus.byte_data, 0);
    chk("midrst_byte_valid", bus.byte_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    vcnt = 0;
    repeat (6) begin
      tick();
      if (bus.byte_valid || busy) vcnt++;
    end
    chk("midrst_no_stale", vcnt, 0);
    run_scan(0, -1, -1);
    verify_scan("after_rst", 4);
    chk("after_rst_first_byte", get_rx(0), ref_byte(0));
    chk("after_rst_first_valid_edge", fv, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bitmap_scanout.md
BITMAP_SCANOUT -- requirements
Module: bitmap_scanout

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the bitmap RAM address width.
REQ-002 SHALL have parameter BYTE_W, default 8, meaning bits packed per output byte.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, scan request; sampled only in IDLE.
REQ-006 SHALL have port ram_addr, output, ADDR_W, read address to the 1-bit bitmap RAM.
REQ-007 SHALL have port ram_q, input, 1, RAM read data, valid one clock after ram_addr is presented (registered-address RAM).
REQ-008 SHALL have port byte_data, output, BYTE_W, packed bitmap byte.
REQ-009 SHALL have port byte_valid, output, 1, byte_data holds a valid byte.
REQ-010 SHALL have port byte_ready, input, 1, consumer accepts the byte when high together with byte_valid.
REQ-011 SHALL have port busy, output, 1, scan in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at scan completion.

Function
REQ-013 SHALL implement states IDLE, FETCH and DRAIN; IDLE->FETCH on start, FETCH->DRAIN once the last address (2**ADDR_W-1) has been read, DRAIN->IDLE on the handshake of the final byte.
REQ-014 SHALL drive ram_addr = 0 in the cycle after start is sampled in IDLE, then advance by 1 per captured bit.
REQ-015 SHALL pack MSB-first: the bit at address BYTE_W*k+i goes to byte k, bit position BYTE_W-1-i.
REQ-016 SHALL emit exactly 2**ADDR_W/BYTE_W bytes per scan (128 at defaults), in ascending k, each exactly once.
REQ-017 SHALL assert byte_valid for byte 0 after the 9th rising edge following the edge that samples start, with byte_ready held high.
REQ-018 SHALL sustain one byte per BYTE_W cycles while byte_ready stays high, so byte k becomes valid after edge 9+8k.
REQ-019 SHALL hold byte_data and byte_valid stable while byte_valid=1 and byte_ready=0.
REQ-020 SHALL stall bit capture when a completed byte cannot enter the output register; it SHALL re-issue the stalled address so no bit is lost or duplicated under any byte_ready pattern.
REQ-021 SHALL permit byte_ready to toggle arbitrarily, including before byte_valid is asserted; a handshake occurs only when byte_valid=1 and byte_ready=1.
REQ-022 SHALL accept a new byte into the output register in the same cycle the current byte handshakes, with no bubble.
REQ-023 SHALL assert busy from the edge after start is sampled until done is asserted; busy and done SHALL NOT be high in the same cycle.
REQ-024 SHALL pulse done for exactly one cycle after the final byte's handshake; at defaults, with ready always high, this follows edge 1026.
REQ-025 SHALL ignore start while busy=1, and SHALL accept start in the cycle after done.
REQ-026 SHALL wrap ram_addr to 0 only at the start of a new scan and SHALL never address beyond 2**ADDR_W-1.

Reset
REQ-027 SHALL, on rst_n low, asynchronously force state=IDLE, ram_addr=0, byte_data=0, byte_valid=0, busy=0 and done=0, and clear the partial-byte count.
REQ-028 SHALL abandon a scan on reset mid-scan; after release, no stale byte appears and the next start scans from address 0.

Structure
REQ-029 SHALL take ADDR_W and BYTE_W defaults, the derived NUM_BYTES, and the state enum from shared package bitmap_pkg.
REQ-030 SHALL place the shift/pack register and bit counter in sub-module bit_packer; the FSM, address counter and output register stay in bitmap_scanout.

Verification
REQ-031 Bench SHALL: RAM preloaded with a bit pattern equal to address[0], byte_ready=1, one start pulse -> 128 bytes all 8'h55, first valid after edge 9, done after edge 1026.
REQ-032 Bench SHALL: all-ones RAM with bit 1023 cleared -> bytes 0..126 = 8'hFF, byte 127 = 8'hFE.
REQ-033 Bench SHALL: random byte_ready (50%) against a random RAM image -> received stream matches the reference packing bit-exact, count = 128, done exactly once.
REQ-034 Bench SHALL: byte_ready=0 for 40 cycles at byte 3 -> byte_data and byte_valid stable throughout, no lost or duplicated byte after release.
REQ-035 Bench SHALL: start re-pulsed at cycle 100 of a scan -> ignored, 128 bytes total; start in the cycle after done -> second scan begins from address 0.
REQ-036 Bench SHALL: rst_n low at byte 60 -> all outputs 0 immediately; after release and start, byte 0 reappears first.
